// File: rtl/mcpu_ctrl.sv
// Purpose : multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB over a shared ALU and one MIO port).
// Latency : controls registered and aligned with `state`; IRWrite/PCWrite in IF and illegal_op follow inputs in the same cycle.
// Backpr. : IF/LWRD/SWWR hold until MIO_ready; a wait of MAX_WAIT cycles (MAX_WAIT>0) latches FAULT.
//
// Ports: clk/rst_n (async active-low); OPcode/Fun from IR; zero (ALU flag, consumed by datapath);
//        MIO_ready (bus done); datapath controls PCWrite..ALU_Control; CPU_MIO bus ownership;
//        illegal_op (ID-cycle pulse); fault (sticky timeout); state (debug).
module mcpu_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       mem_w,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_Control,
    output logic       CPU_MIO,
    output logic       illegal_op,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_INIT = 4'd0,  S_IF   = 4'd1,  S_ID   = 4'd2,  S_MA   = 4'd3,
        S_LWRD = 4'd4,  S_LWWB = 4'd5,  S_SWWR = 4'd6,  S_REX  = 4'd7,
        S_RWB  = 4'd8,  S_BEQ  = 4'd9,  S_J    = 4'd10, S_IEX  = 4'd11,
        S_IWB  = 4'd12, S_FAULT = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_w;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_ctl;
        logic       cpu_mio;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'h00, OP_LW   = 6'h23, OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04, OP_J    = 6'h02, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_SLTI = 6'h0a;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    // Counter only needs to reach MAX_WAIT-1: the cycle after that is the timeout.
    localparam int CW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int LIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = LIM[CW-1:0];

    state_t        st_q, st_nxt;
    ctrl_t         ctrl_q;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    logic          timeout;

    // zero gates PCWriteCond inside the datapath; the port exists for pin compatibility only.
    logic unused_zero;
    assign unused_zero = zero;

    function automatic logic fun_ok(input logic [5:0] f);
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h02, 6'h26: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_ok(input logic [5:0] op, input logic [5:0] f);
        case (op)
            OP_R: return fun_ok(f);
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2a:   return ALU_SLT;
            6'h27:   return ALU_NOR;
            6'h02:   return ALU_SRL;
            6'h26:   return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Moore control word for a state; op/f are stable in IR for the whole instruction after IF.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF:   begin c.mem_read = 1'b1; c.cpu_mio = 1'b1; c.alu_src_b = 2'b01; c.alu_ctl = ALU_ADD; end
            S_ID:   begin c.alu_src_b = 2'b11; c.alu_ctl = ALU_ADD; end
            S_MA:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = ALU_ADD; end
            S_LWRD: begin c.mem_read = 1'b1; c.iord = 1'b1; c.cpu_mio = 1'b1; end
            S_LWWB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_SWWR: begin c.mem_w = 1'b1; c.iord = 1'b1; c.cpu_mio = 1'b1; end
            S_REX:  begin c.alu_src_a = 1'b1; c.alu_ctl = r_alu(f); end
            S_RWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BEQ:  begin c.alu_src_a = 1'b1; c.alu_ctl = ALU_SUB; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            S_J:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_IEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = i_alu(op); end
            S_IWB:  begin c.reg_write = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    assign timeout = (MAX_WAIT > 0) && (wait_cnt == LIMIT) && !MIO_ready;

    always_comb begin
        st_nxt = st_q;
        case (st_q)
            S_INIT: st_nxt = S_IF;
            S_IF:   st_nxt = MIO_ready ? S_ID : (timeout ? S_FAULT : S_IF);
            S_ID: begin
                if (!op_ok(OPcode, Fun))                     st_nxt = S_IF;
                else if (OPcode == OP_R)                     st_nxt = S_REX;
                else if (OPcode == OP_LW || OPcode == OP_SW) st_nxt = S_MA;
                else if (OPcode == OP_BEQ)                   st_nxt = S_BEQ;
                else if (OPcode == OP_J)                     st_nxt = S_J;
                else                                         st_nxt = S_IEX;
            end
            S_MA:   st_nxt = (OPcode == OP_LW) ? S_LWRD : S_SWWR;
            S_LWRD: st_nxt = MIO_ready ? S_LWWB : (timeout ? S_FAULT : S_LWRD);
            S_SWWR: st_nxt = MIO_ready ? S_IF : (timeout ? S_FAULT : S_SWWR);
            S_REX:  st_nxt = S_RWB;
            S_IEX:  st_nxt = S_IWB;
            S_FAULT: st_nxt = S_FAULT;
            default: st_nxt = S_IF;
        endcase
    end

    // Only the three bus states and FAULT can remain in place, so "state unchanged"
    // outside FAULT means a wait cycle; any transition restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_INIT;
            ctrl_q   <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            st_q   <= st_nxt;
            ctrl_q <= decode(st_nxt, OPcode, Fun);
            if (st_nxt == S_FAULT)
                fault_q <= 1'b1;
            if (st_nxt != st_q)
                wait_cnt <= '0;
            else if ((MAX_WAIT > 0) && !MIO_ready && st_q != S_FAULT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign PCWrite     = ctrl_q.pc_write | ((st_q == S_IF) & MIO_ready);
    assign IRWrite     = (st_q == S_IF) & MIO_ready;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign mem_w       = ctrl_q.mem_w;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign PCSource    = ctrl_q.pc_source;
    assign ALU_Control = ctrl_q.alu_ctl;
    assign CPU_MIO     = ctrl_q.cpu_mio;
    assign illegal_op  = (st_q == S_ID) & !op_ok(OPcode, Fun);
    assign fault       = fault_q;
    assign state       = st_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Purpose : randomized self-checking bench for mcpu_ctrl against a per-instruction trace model.
// Latency : expected per-cycle state/control traces are built from instruction class and wait counts.
// Backpr. : MIO_ready wait cycles are planned up front; timeout and async reset are exercised directly.
module tb_mcpu_ctrl;

    localparam int IF = 1, ID = 2, MA = 3, LWRD = 4, LWWB = 5, SWWR = 6, REX = 7;
    localparam int RWB = 8, BEQ = 9, JJ = 10, IEX = 11, IWB = 12, FLT = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OPcode, Fun;
    logic       zero, MIO_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, MemtoReg, RegDst, RegWrite;
    logic       ALUSrcA, CPU_MIO, illegal_op, fault;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALU_Control;
    logic [3:0] state;
    logic [19:0] outs;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct { int st; logic rdy; } step_t;
    step_t q[$];

    always #5 clk = ~clk;

    mcpu_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .mem_w(mem_w),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_Control(ALU_Control), .CPU_MIO(CPU_MIO),
        .illegal_op(illegal_op), .fault(fault), .state(state)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, MemtoReg, RegDst, RegWrite,
                   ALUSrcA, ALUSrcB, PCSource, ALU_Control, CPU_MIO, illegal_op, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Instruction-set tables: I/J/memory opcodes, R-type functs and their ALU codes (same index).
    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] ops  [8] = '{6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
        logic [5:0] funs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h02, 6'h26};
        if (op == 6'h00) begin
            foreach (funs[i]) if (funs[i] == fn) return 1'b1;
            return 1'b0;
        end
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] fun_alu(input logic [5:0] fn);
        logic [5:0] funs  [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h02, 6'h26};
        logic [2:0] codes [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101, 3'b011};
        foreach (funs[i]) if (funs[i] == fn) return codes[i];
        return 3'b010;
    endfunction

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        if (op == 6'h0c) return 3'b000;
        if (op == 6'h0d) return 3'b001;
        if (op == 6'h0a) return 3'b111;
        return 3'b010;
    endfunction

    // Expected control outputs for one cycle of a given state.
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                            input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, mio, ill, flt;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, mio, ill, flt} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (st)
            IF:   begin mr = 1; mio = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
            ID:   begin asb = 2'b11; alu = 3'b010; ill = !is_legal(op, fn); end
            MA:   begin asa = 1; asb = 2'b10; alu = 3'b010; end
            LWRD: begin mr = 1; iord = 1; mio = 1; end
            LWWB: begin rw = 1; m2r = 1; end
            SWWR: begin mw = 1; iord = 1; mio = 1; end
            REX:  begin asa = 1; alu = fun_alu(fn); end
            RWB:  begin rw = 1; rd = 1; end
            BEQ:  begin asa = 1; alu = 3'b110; pcwc = 1; pcs = 2'b01; end
            JJ:   begin pcw = 1; pcs = 2'b10; end
            IEX:  begin asa = 1; asb = 2'b10; alu = imm_alu(op); end
            IWB:  begin rw = 1; end
            FLT:  begin flt = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, alu, mio, ill, flt};
    endfunction

    task automatic push(input int st, input logic rdy);
        step_t s;
        s.st = st; s.rdy = rdy;
        q.push_back(s);
    endtask

    // A bus phase: w cycles with MIO_ready low, then one with it high.
    task automatic bus_phase(input int st, input int w);
        for (int i = 0; i < w; i++) push(st, 1'b0);
        push(st, 1'b1);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wif, input int wmem);
        q.delete();
        bus_phase(IF, wif);
        push(ID, 1'($urandom));
        if (is_legal(op, fn)) begin
            case (op)
                6'h00: begin push(REX, 1'($urandom)); push(RWB, 1'($urandom)); end
                6'h23: begin push(MA, 1'($urandom)); bus_phase(LWRD, wmem); push(LWWB, 1'($urandom)); end
                6'h2b: begin push(MA, 1'($urandom)); bus_phase(SWWR, wmem); end
                6'h04: push(BEQ, 1'($urandom));
                6'h02: push(JJ, 1'($urandom));
                default: begin push(IEX, 1'($urandom)); push(IWB, 1'($urandom)); end
            endcase
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 after the last step.
    task automatic run_steps(input string tag);
        foreach (q[i]) begin
            MIO_ready = q[i].rdy;
            zero      = 1'($urandom);
            @(negedge clk);
            chk({tag, ".state"}, 32'(state), 32'(q[i].st));
            chk({tag, ".ctl"}, 32'(outs), 32'(exp_out(q[i].st, OPcode, Fun, q[i].rdy)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int wif, input int wmem);
        OPcode = op;
        Fun    = fn;
        build(op, fn, wif, wmem);
        run_steps(tag);
    endtask

    task automatic reset_and_init(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        chk({tag, ".rst_state"}, 32'(state), 32'd0);
        chk({tag, ".rst_ctl"}, 32'(outs), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".init_state"}, 32'(state), 32'd0);
        chk({tag, ".init_ctl"}, 32'(outs), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops  [8] = '{6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
        logic [5:0] funs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h02, 6'h26};
        logic [5:0] op, fn;
        rst_n = 1'b0; OPcode = 6'h00; Fun = 6'h20; zero = 1'b0; MIO_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_and_init("reset");

        // Directed cases
        run_instr("add",    6'h00, 6'h20, 0, 0);
        run_instr("lw_w3",  6'h23, 6'h00, 0, 3);
        run_instr("beq",    6'h04, 6'h11, 0, 0);
        run_instr("j",      6'h02, 6'h00, 1, 0);
        run_instr("illop",  6'h3f, 6'h20, 0, 0);
        run_instr("badfun", 6'h00, 6'h21, 2, 0);
        run_instr("sw_w3",  6'h2b, 6'h00, 3, 3);
        run_instr("slti",   6'h0a, 6'h00, 0, 0);

        // Randomized instruction stream, waits kept below the timeout
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 10);
            if (r < 8) begin
                op = ops[r]; fn = 6'($urandom);
            end else if (r < 10) begin
                op = 6'h00; fn = funs[$urandom_range(0, 7)];
            end else begin
                op = 6'($urandom); fn = 6'($urandom);
            end
            run_instr("rand", op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Store that never completes: four wait cycles, then absorbing FAULT
        OPcode = 6'h2b; Fun = 6'h00;
        q.delete();
        push(IF, 1'b1); push(ID, 1'b0); push(MA, 1'b0);
        for (int i = 0; i < 4; i++) push(SWWR, 1'b0);
        push(FLT, 1'b0); push(FLT, 1'b1); push(FLT, 1'b0);
        run_steps("timeout");

        // Reset also clears the sticky fault
        reset_and_init("fault_clr");

        // Asynchronous reset in the middle of a store wait
        OPcode = 6'h2b; Fun = 6'h00;
        q.delete();
        push(IF, 1'b1); push(ID, 1'b1); push(MA, 1'b1); push(SWWR, 1'b0);
        run_steps("sw_abort");
        MIO_ready = 1'b0;
        #2;
        chk("sw_abort.mem_w_pre", 32'(mem_w), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_abort.mem_w_async", 32'(mem_w), 32'd0);
        chk("sw_abort.state_async", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MIO_ready = 1'b1;
        @(negedge clk);
        chk("sw_abort.init_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        run_instr("after_rst", 6'h02, 6'h00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
